// File: rtl/i_fetch.sv
// Instruction fetch stage: program-loadable instruction memory, PC register and
// IF/ID pipeline registers, sequenced by a LOAD/RUN/HALT state machine.
module i_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 64,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load_en,
  input  logic [AW-1:0]         i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_start,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halted,
  output logic [DATA_WIDTH-1:0] o_fetch_count,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] cpc_q, cpc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] imem_q [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  fetch_is_halt;

  // Memory has no reset so a program survives a reset and can be re-run.
  always_ff @(posedge i_clock) begin
    if (state_q == LOAD && i_load_en) begin
      imem_q[i_load_addr] <= i_load_data;
    end
  end

  assign fetch_word    = imem_q[pc_q[AW+1:2]];
  assign fetch_is_halt = (fetch_word[31:26] == 6'b111111);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cpc_d   = cpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (i_start) state_d = RUN;
      end
      RUN: begin
        // Stall freezes everything; a pending branch is re-presented by decode.
        if (!i_stall) begin
          if (i_branch_taken) begin
            pc_d    = i_pcbranch;
            instr_d = '0;
            cpc_d   = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = fetch_word;
            cpc_d   = pc_q + DATA_WIDTH'(4);
            valid_d = 1'b1;
            cnt_d   = cnt_q + DATA_WIDTH'(1);
            if (fetch_is_halt) begin
              state_d = HALT;
            end else begin
              pc_d = pc_q + DATA_WIDTH'(4);
            end
          end
        end
      end
      HALT: begin
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= LOAD;
      pc_q    <= '0;
      instr_q <= '0;
      cpc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cpc_q   <= cpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_instruccion = instr_q;
  assign o_currentpc   = cpc_q;
  assign o_valid       = valid_q;
  assign o_pc          = pc_q;
  assign o_halted      = (state_q == HALT);
  assign o_fetch_count = cnt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: load, run to halt, reset behaviour, branch,
// stall-with-branch, PC wrap and halt-input masking.
module tb_i_fetch;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_load_en;
  logic [AW-1:0] i_load_addr;
  logic [DW-1:0] i_load_data;
  logic          i_start;
  logic          i_stall;
  logic          i_branch_taken;
  logic [DW-1:0] i_pcbranch;
  logic [DW-1:0] o_instruccion;
  logic [DW-1:0] o_currentpc;
  logic          o_valid;
  logic [DW-1:0] o_pc;
  logic          o_halted;
  logic [DW-1:0] o_fetch_count;
  logic [1:0]    o_state;

  int n_cmp = 0;
  int n_err = 0;

  i_fetch #(.DATA_WIDTH(DW), .IMEM_DEPTH(DEPTH)) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_load_en      (i_load_en),
    .i_load_addr    (i_load_addr),
    .i_load_data    (i_load_data),
    .i_start        (i_start),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_pcbranch     (i_pcbranch),
    .o_instruccion  (o_instruccion),
    .o_currentpc    (o_currentpc),
    .o_valid        (o_valid),
    .o_pc           (o_pc),
    .o_halted       (o_halted),
    .o_fetch_count  (o_fetch_count),
    .o_state        (o_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_load_en   = 1'b1;
    i_load_addr = a;
    i_load_data = d;
    step();
    i_load_en   = 1'b0;
  endtask

  task automatic chk_fetch(input string tag, input logic [DW-1:0] ins, input logic [DW-1:0] cpc,
                           input logic [DW-1:0] pc, input logic [DW-1:0] cnt);
    chk({tag, "_instr"}, o_instruccion, ins);
    chk({tag, "_cpc"},   o_currentpc,   cpc);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_pc"},    o_pc,          pc);
    chk({tag, "_cnt"},   o_fetch_count, cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"},  o_instruccion, 32'h0);
    chk({tag, "_cpc"},    o_currentpc,   32'h0);
    chk({tag, "_valid"},  {31'd0, o_valid},  32'd0);
    chk({tag, "_pc"},     o_pc,          32'h0);
    chk({tag, "_halted"}, {31'd0, o_halted}, 32'd0);
    chk({tag, "_cnt"},    o_fetch_count, 32'h0);
    chk({tag, "_state"},  {30'd0, o_state},  32'd0);
  endtask

  initial begin
    i_reset = 1'b0; i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0;
    i_start = 1'b0; i_stall = 1'b0; i_branch_taken = 1'b0; i_pcbranch = '0;
    step(); step();
    chk_zero("reset");
    i_reset = 1'b1;

    // Program load; the last write shares its edge with start.
    load(6'd16, 32'hAAAA0001);
    load(6'd63, 32'h12345678);
    load(6'd0,  32'h20010005);
    load(6'd1,  32'h20020003);
    i_start = 1'b1;
    load(6'd2,  32'hFC000000);
    i_start = 1'b0;
    chk("start_state", {30'd0, o_state}, 32'd1);
    chk("start_valid", {31'd0, o_valid}, 32'd0);

    step(); chk_fetch("f0", 32'h20010005, 32'd4,  32'd4, 32'd1);
    step(); chk_fetch("f1", 32'h20020003, 32'd8,  32'd8, 32'd2);
    step(); chk_fetch("f2", 32'hFC000000, 32'd12, 32'd8, 32'd3);
    chk("f2_halted", {31'd0, o_halted}, 32'd1);
    step();
    chk("halt_instr", o_instruccion, 32'h0);
    chk("halt_valid", {31'd0, o_valid}, 32'd0);
    chk("halt_cnt", o_fetch_count, 32'd3);
    chk("halt_pc", o_pc, 32'd8);

    // All inputs ignored in HALT (the write to word 0 is checked by the re-run).
    i_start = 1'b1; i_load_en = 1'b1; i_load_addr = 6'd0; i_load_data = 32'h0;
    i_branch_taken = 1'b1; i_pcbranch = 32'h100;
    step();
    i_start = 1'b0; i_load_en = 1'b0; i_branch_taken = 1'b0;
    chk("hold_pc", o_pc, 32'd8);
    chk("hold_cnt", o_fetch_count, 32'd3);
    chk("hold_halted", {31'd0, o_halted}, 32'd1);

    // Asynchronous reset between edges, from HALT.
    #2 i_reset = 1'b0;
    #1 chk_zero("rst_halt");
    step(); i_reset = 1'b1;

    i_start = 1'b1; step(); i_start = 1'b0;
    i_load_en = 1'b1; i_load_addr = 6'd1; i_load_data = 32'hDEADBEEF;
    step(); i_load_en = 1'b0;
    chk_fetch("r0", 32'h20010005, 32'd4, 32'd4, 32'd1);

    // Asynchronous reset mid-RUN.
    #2 i_reset = 1'b0;
    #1 chk_zero("rst_run");
    step(); i_reset = 1'b1;

    i_start = 1'b1; step(); i_start = 1'b0;
    step(); chk_fetch("p0", 32'h20010005, 32'd4, 32'd4, 32'd1);
    step(); chk_fetch("p1", 32'h20020003, 32'd8, 32'd8, 32'd2);

    // Branch while the HALT word at PC 8 is being fetched.
    i_branch_taken = 1'b1; i_pcbranch = 32'h40;
    step(); i_branch_taken = 1'b0;
    chk("br_instr", o_instruccion, 32'h0);
    chk("br_cpc", o_currentpc, 32'h0);
    chk("br_valid", {31'd0, o_valid}, 32'd0);
    chk("br_pc", o_pc, 32'h40);
    chk("br_halted", {31'd0, o_halted}, 32'd0);
    chk("br_cnt", o_fetch_count, 32'd2);
    step(); chk_fetch("b0", 32'hAAAA0001, 32'h44, 32'h44, 32'd3);

    i_stall = 1'b1; i_branch_taken = 1'b1; i_pcbranch = 32'h0;
    for (int k = 0; k < 3; k++) begin
      step(); chk_fetch($sformatf("stall%0d", k), 32'hAAAA0001, 32'h44, 32'h44, 32'd3);
    end
    i_stall = 1'b0; i_pcbranch = 32'hFFFFFFFC;
    step(); i_branch_taken = 1'b0;
    chk("wrapbr_pc", o_pc, 32'hFFFFFFFC);
    chk("wrapbr_valid", {31'd0, o_valid}, 32'd0);
    step(); chk_fetch("wrap", 32'h12345678, 32'h0, 32'h0, 32'd4);
    step(); chk_fetch("w0", 32'h20010005, 32'd4, 32'd4, 32'd5);
    step(); chk_fetch("w1", 32'h20020003, 32'd8, 32'd8, 32'd6);
    step(); chk_fetch("w2", 32'hFC000000, 32'd12, 32'd8, 32'd7);
    step();
    chk("end_valid", {31'd0, o_valid}, 32'd0);
    chk("end_halted", {31'd0, o_halted}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
